ctrl_seq: RTL and testbench

Instruction-cycle control sequencer for the 8-bit accumulator CPU. It drives the instruction-register load strobe `iir`, then consumes the IR's one-hot decoded lines (LD/ADD/SUB/AND/OR/STO/HALT). From those lines it produces per-cycle micro-operation strobes for the PC, MAR, memory, ALU and accumulator. It is the control-side counterpart of the IR decoder and sits between the IR and the datapath.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/ctrl_seq_if.sv | 39 +++
 rtl/ctrl_onehot_chk.sv | 26 ++
 rtl/ctrl_seq.sv | 130 +++++++++++++
 tb/tb_ctrl_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the accumulator-CPU control sequencer.
// Holds the state enum, op-register encoding, ALU codes and strobe bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_DEC,
        S_E0,
        S_E1,
        S_HALTED
    } state_e;

    // Op index follows the IR line order, so LD..OR line up with the ALU codes
    typedef enum logic [2:0] {
        OP_LD,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_STO,
        OP_HALT
    } op_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    typedef struct packed {
        logic       iir;
        logic       pc_inc;
        logic       mar_sel_pc;
        logic       mar_sel_ir;
        logic       mem_rd;
        logic       mem_wr;
        logic       acc_ld;
        logic [2:0] alu_op;
        logic       running;
        logic       halted;
    } strb_t;

    function automatic logic [2:0] op_to_alu(op_e op);
        logic [2:0] a;
        a = ALU_PASS;
        case (op)
            OP_ADD:  a = ALU_ADD;
            OP_SUB:  a = ALU_SUB;
            OP_AND:  a = ALU_AND;
            OP_OR:   a = ALU_OR;
            default: a = ALU_PASS;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: IR decode lines in, datapath micro-op strobes out.
// The icnt signal exists only when CTRL_SEQ_ICNT_EN is defined.
interface ctrl_seq_if #(
    parameter int ICNT_W = 16
);
    logic       start;
    logic       ld, add, sub, and_i, or_i, sto, halt;
    logic       iir, pc_inc, mar_sel_pc, mar_sel_ir;
    logic       mem_rd, mem_wr, acc_ld;
    logic [2:0] alu_op;
    logic       running, halted, err;
`ifdef CTRL_SEQ_ICNT_EN
    logic [ICNT_W-1:0] icnt;
`else
    logic [ICNT_W-1:0] icnt_unused;
    assign icnt_unused = '0;
`endif

    modport master (
`ifdef CTRL_SEQ_ICNT_EN
        output icnt,
`endif
        input  start, ld, add, sub, and_i, or_i, sto, halt,
        output iir, pc_inc, mar_sel_pc, mar_sel_ir,
        output mem_rd, mem_wr, acc_ld, alu_op,
        output running, halted, err
    );

    modport slave (
`ifdef CTRL_SEQ_ICNT_EN
        input  icnt,
`endif
        output start, ld, add, sub, and_i, or_i, sto, halt,
        input  iir, pc_inc, mar_sel_pc, mar_sel_ir,
        input  mem_rd, mem_wr, acc_ld, alu_op,
        input  running, halted, err
    );

endinterface

// File: rtl/ctrl_onehot_chk.sv
// ctrl_onehot_chk: flags whether exactly one IR decode line is high
// and returns the index of the highest set line.
module ctrl_onehot_chk
    import ctrl_pkg::*;
(
    input  logic [6:0] lines_i,
    output logic       valid_one_o,
    output op_e        idx_o
);

    logic [2:0] cnt;

    always_comb begin
        cnt   = '0;
        idx_o = OP_LD;
        for (int i = 0; i < 7; i++) begin
            if (lines_i[i]) begin
                cnt   = cnt + 3'd1;
                idx_o = op_e'(i[2:0]);
            end
        end
    end

    assign valid_one_o = (cnt == 3'd1);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define CTRL_SEQ_ICNT_EN to add the retired-instruction counter.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int ICNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_seq_if.master bus
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    strb_t  strb_q, strb_d;
    logic   err_q, err_d;
    logic   valid_one;
    op_e    idx;

    ctrl_onehot_chk u_chk (
        .lines_i     ({bus.halt, bus.sto, bus.or_i, bus.and_i,
                       bus.sub, bus.add, bus.ld}),
        .valid_one_o (valid_one),
        .idx_o       (idx)
    );

    // Strobes are computed from the next state so they register with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LD;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_DEC;
            S_DEC: begin
                if (!valid_one) begin
                    if (ILLEGAL_HALT) begin
                        state_d = S_HALTED;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_F0;
                    end
                end else if (idx == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_E0;
                    op_d    = idx;
                end
            end
            S_E0:     state_d = S_E1;
            S_E1:     state_d = S_F0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        strb_d = '0;
        unique case (state_d)
            S_F0: begin
                strb_d.mar_sel_pc = 1'b1;
                strb_d.mem_rd     = 1'b1;
            end
            S_F1: begin
                strb_d.mem_rd = 1'b1;
                strb_d.iir    = 1'b1;
                strb_d.pc_inc = 1'b1;
            end
            S_E0: strb_d.mar_sel_ir = 1'b1;
            S_E1: begin
                if (op_d == OP_STO) begin
                    strb_d.mem_wr = 1'b1;
                end else begin
                    strb_d.mem_rd = 1'b1;
                    strb_d.acc_ld = 1'b1;
                    strb_d.alu_op = op_to_alu(op_d);
                end
            end
            default: ;
        endcase
        strb_d.running = (state_d != S_IDLE) && (state_d != S_HALTED);
        strb_d.halted  = (state_d == S_HALTED);
    end

    assign bus.iir        = strb_q.iir;
    assign bus.pc_inc     = strb_q.pc_inc;
    assign bus.mar_sel_pc = strb_q.mar_sel_pc;
    assign bus.mar_sel_ir = strb_q.mar_sel_ir;
    assign bus.mem_rd     = strb_q.mem_rd;
    assign bus.mem_wr     = strb_q.mem_wr;
    assign bus.acc_ld     = strb_q.acc_ld;
    assign bus.alu_op     = strb_q.alu_op;
    assign bus.running    = strb_q.running;
    assign bus.halted     = strb_q.halted;
    assign bus.err        = err_q;

`ifdef CTRL_SEQ_ICNT_EN
    logic [ICNT_W-1:0] icnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icnt_q <= '0;
        end else if (state_q == S_E1) begin
            icnt_q <= icnt_q + 1'b1;
        end
    end

    assign bus.icnt = icnt_q;
`else
    logic [ICNT_W-1:0] icnt_unused;
    assign icnt_unused = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: two sequencers (illegal->halt/16-bit count, illegal->NOP/2-bit
// count) run the same programs against a program-level trace model.
module tb_ctrl_seq;

    typedef struct packed {
        logic       iir, pc_inc, mar_pc, mar_ir, rd, wr, acc;
        logic [2:0] alu;
        logic       run, hlt, err;
    } obs_t;

    typedef struct {
        obs_t w;
        int   ic;
    } exp_t;

    typedef struct {
        logic [6:0] ln;
        logic [2:0] alu;
        logic       wr, acc, hlt_a, err_a, nop_b;
    } vec_t;

    localparam logic [6:0] I_LD  = 7'h01;
    localparam logic [6:0] I_ADD = 7'h02;
    localparam logic [6:0] I_SUB = 7'h04;
    localparam logic [6:0] I_AND = 7'h08;
    localparam logic [6:0] I_OR  = 7'h10;
    localparam logic [6:0] I_STO = 7'h20;
    localparam logic [6:0] I_HLT = 7'h40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_seq_if #(.ICNT_W(16)) ifa ();
    ctrl_seq_if #(.ICNT_W(2))  ifb ();

    ctrl_seq #(.ILLEGAL_HALT(1'b1), .ICNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    ctrl_seq #(.ILLEGAL_HALT(1'b0), .ICNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [6:0] ln [2];
    assign ifa.start = start;
    assign ifb.start = start;
    assign {ifa.halt, ifa.sto, ifa.or_i, ifa.and_i,
            ifa.sub, ifa.add, ifa.ld} = ln[0];
    assign {ifb.halt, ifb.sto, ifb.or_i, ifb.and_i,
            ifb.sub, ifb.add, ifb.ld} = ln[1];

    obs_t obs [2];
    int   ic_obs [2];
    assign obs[0] = {ifa.iir, ifa.pc_inc, ifa.mar_sel_pc, ifa.mar_sel_ir,
                     ifa.mem_rd, ifa.mem_wr, ifa.acc_ld, ifa.alu_op,
                     ifa.running, ifa.halted, ifa.err};
    assign obs[1] = {ifb.iir, ifb.pc_inc, ifb.mar_sel_pc, ifb.mar_sel_ir,
                     ifb.mem_rd, ifb.mem_wr, ifb.acc_ld, ifb.alu_op,
                     ifb.running, ifb.halted, ifb.err};
`ifdef CTRL_SEQ_ICNT_EN
    assign ic_obs[0] = int'(ifa.icnt);
    assign ic_obs[1] = int'(ifb.icnt);
`else
    assign ic_obs[0] = 0;
    assign ic_obs[1] = 0;
`endif

    // Program memory + IR: next word appears on the lines while iir is high
    logic [6:0] pq [2][$];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (obs[k].iir) begin
                if (pq[k].size() > 0) ln[k] = pq[k].pop_front();
                else ln[k] = I_HLT;
            end
        end
    end

    exp_t ex [2][$];
    obs_t hist [2][$];
    int   hic [2][$];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // ph: 0 F0, 1 F1, 2 DEC, 3 E0, 4 E1, else HALTED
    function automatic obs_t word(int ph, int op, logic e);
        obs_t w;
        w = '0;
        w.run = 1'b1;
        case (ph)
            0: begin w.mar_pc = 1'b1; w.rd = 1'b1; end
            1: begin w.rd = 1'b1; w.iir = 1'b1; w.pc_inc = 1'b1; end
            2: ;
            3: w.mar_ir = 1'b1;
            4: begin
                if (op == 5) w.wr = 1'b1;
                else begin
                    w.rd  = 1'b1;
                    w.acc = 1'b1;
                    w.alu = 3'(op);
                end
            end
            default: begin w.run = 1'b0; w.hlt = 1'b1; end
        endcase
        w.err = e;
        return w;
    endfunction

    function automatic exp_t mk(obs_t w, int ic);
        exp_t x;
        x.w  = w;
        x.ic = ic;
        return x;
    endfunction

    // Expand a program into the expected per-cycle trace for instance k
    task automatic build(int k, input logic [6:0] p [$], int len);
        int   ret = 0;
        logic e = 1'b0;
        bit   done = 0;
        int   mask = (k == 0) ? 'hFFFF : 3;
        ex[k].delete();
        foreach (p[i]) begin
            int n, op;
            if (done) break;
            n  = $countones(p[i]);
            op = 0;
            for (int b = 0; b < 7; b++) if (p[i][b]) op = b;
            for (int ph = 0; ph < 3; ph++)
                ex[k].push_back(mk(word(ph, 0, 1'b0), ret & mask));
            if (n == 1 && op == 6) begin
                done = 1;
            end else if (n != 1) begin
                if (k == 0) begin
                    e    = 1'b1;
                    done = 1;
                end
            end else begin
                ex[k].push_back(mk(word(3, op, 1'b0), ret & mask));
                ex[k].push_back(mk(word(4, op, 1'b0), ret & mask));
                ret++;
            end
        end
        while (ex[k].size() < len)
            ex[k].push_back(mk(word(5, 0, e), ret & mask));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_out%0d", k), obs[k], '0);
`ifdef CTRL_SEQ_ICNT_EN
            chk($sformatf("rst_icnt%0d", k), ic_obs[k], 0);
`endif
        end
    endtask

    // start is held high for the whole run; it must only matter in IDLE
    task automatic run_prog(input logic [6:0] p [$]);
        int len = 5 * p.size() + 8;
        build(0, p, len);
        build(1, p, len);
        do_reset();
        pq[0] = p;
        pq[1] = p;
        hist[0].delete();
        hist[1].delete();
        hic[0].delete();
        hic[1].delete();
        rst_n = 1'b1;
        start = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                hist[k].push_back(obs[k]);
                hic[k].push_back(ic_obs[k]);
                chk($sformatf("trace%0d_c%0d", k, c), obs[k], ex[k][c].w);
`ifdef CTRL_SEQ_ICNT_EN
                chk($sformatf("icnt%0d_c%0d", k, c), ic_obs[k], ex[k][c].ic);
`endif
            end
        end
        start = 1'b0;
    endtask

    task automatic rst_mid();
        logic [6:0] p [$];
        p = '{I_STO, I_HLT};
        do_reset();
        pq[0] = p;
        pq[1] = p;
        rst_n = 1'b1;
        start = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_sto_wr", obs[0].wr, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_a", obs[0], '0);
        chk("mid_rst_b", obs[1], '0);
`ifdef CTRL_SEQ_ICNT_EN
        chk("mid_rst_icnt", ic_obs[0], 0);
`endif
        start = 1'b0;
    endtask

    initial begin
        vec_t       tbl [9];
        logic [6:0] p [$];
        ln[0] = '0;
        ln[1] = '0;
        tbl[0] = '{I_LD,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{I_ADD, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{I_SUB, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{I_AND, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{I_OR,  3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{I_STO, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{I_HLT, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{7'h06, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 9; i++) begin
            p = '{tbl[i].ln, I_HLT};
            run_prog(p);
            if (tbl[i].hlt_a) begin
                chk($sformatf("tbl%0d_hlt", i), hist[0][3].hlt, 1);
                chk($sformatf("tbl%0d_err", i), hist[0][3].err, tbl[i].err_a);
            end else begin
                chk($sformatf("tbl%0d_alu", i), hist[0][4].alu, tbl[i].alu);
                chk($sformatf("tbl%0d_wr", i), hist[0][4].wr, tbl[i].wr);
                chk($sformatf("tbl%0d_acc", i), hist[0][4].acc, tbl[i].acc);
            end
            if (tbl[i].nop_b) begin
                chk($sformatf("tbl%0d_nop_f0", i), hist[1][3].mar_pc, 1);
                chk($sformatf("tbl%0d_nop_err", i), hist[1][3].err, 0);
`ifdef CTRL_SEQ_ICNT_EN
                chk($sformatf("tbl%0d_nop_icnt", i), hic[1][3], 0);
`endif
            end
        end

        p = '{I_LD, I_LD, I_HLT};
        run_prog(p);
        chk("ld_iir_c2", hist[0][1].iir, 1);
        chk("ld_acc_c5", hist[0][4].acc, 1);
        chk("ld_alu_c5", hist[0][4].alu, 0);
        chk("ld_f0_c6", hist[0][5].mar_pc, 1);

        p = '{I_ADD, I_SUB, I_AND, I_OR, I_STO, I_HLT};
        run_prog(p);
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_alu%0d", i), hist[0][4 + 5 * i].alu, i + 1);
        chk("seq_sto_wr", hist[0][24].wr, 1);
        chk("seq_sto_acc", hist[0][24].acc, 0);
`ifdef CTRL_SEQ_ICNT_EN
        chk("seq_icnt", hic[0][25], 5);
`endif

        p = '{I_HLT};
        run_prog(p);
        chk("halt_c4", hist[0][3].hlt, 1);
        chk("halt_run", hist[0][3].run, 0);
        chk("halt_start_ign", hist[0][12].hlt, 1);

        p = '{I_LD, I_LD, I_LD, I_LD, I_LD, I_HLT};
        run_prog(p);
`ifdef CTRL_SEQ_ICNT_EN
        for (int j = 1; j <= 5; j++)
            chk($sformatf("wrap%0d", j), hic[1][5 * j], j % 4);
`endif

        rst_mid();

        repeat (25) begin
            int n;
            n = $urandom_range(1, 6);
            p.delete();
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) p.push_back(7'(1 << r));
                else if (r < 9) p.push_back(7'($urandom));
                else p.push_back(I_HLT);
            end
            p.push_back(I_HLT);
            run_prog(p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
